// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the EX/MEM stage and its store-lane helper.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Conditional branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Store funct3 codes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Access size carried in funct3[1:0] for both loads and stores
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  // Bit positions inside ctl = {RegWrite, MemRead, MemWrite, MemtoReg}
  localparam int CTL_REGWRITE = 3;
  localparam int CTL_MEMREAD  = 2;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_MEMTOREG = 0;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for stores plus misalignment detection.
module store_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size_i,      // funct3[1:0]
  input  logic [1:0]  addr_i,      // low address bits
  input  logic [31:0] rs2_i,
  input  logic        access_i,    // MemRead | MemWrite
  input  logic        write_i,     // MemWrite
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        misalign_o
);

  logic [3:0] strb_raw;
  logic       mis_raw;

  // Replicate the store datum across lanes and pick the lanes it lands in
  always_comb begin
    wdata_o  = rs2_i;
    strb_raw = 4'b0000;
    mis_raw  = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        wdata_o  = {4{rs2_i[7:0]}};
        strb_raw = 4'b0001 << addr_i;
      end
      SZ_HALF: begin
        wdata_o  = {2{rs2_i[15:0]}};
        strb_raw = addr_i[1] ? 4'b1100 : 4'b0011;
        mis_raw  = addr_i[0];
      end
      SZ_WORD: begin
        strb_raw = 4'b1111;
        mis_raw  = |addr_i;
      end
      default: ;
    endcase
    misalign_o = access_i & mis_raw;
    // A misaligned store must not touch memory at all
    wstrb_o    = (write_i && !mis_raw) ? strb_raw : 4'b0000;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and control, resolves branches,
// aligns store data and exposes the EX->EX forwarding source.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic              ex_zero,
  input  logic              ex_less,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [2:0]        ex_funct3,
  input  logic [3:0]        ex_ctl,
  input  logic              ex_branch,
  input  logic              ex_jump,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_pc,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic [REG_AW-1:0] mem_rd,
  output logic [3:0]        mem_ctl,
  output logic [2:0]        mem_funct3,
  output logic              mem_misalign,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wdata;
    logic [3:0]        wstrb;
    logic [REG_AW-1:0] rd;
    logic [3:0]        ctl;
    logic [2:0]        funct3;
    logic              misalign;
    logic              taken;
    logic [XLEN-1:0]   target;
  } stage_t;

  stage_t stage_q, stage_d;
  logic   redirect_done_q, redirect_done_d;

  logic        cond_met;
  logic        taken;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_misalign;

  store_lane_align u_align (
    .size_i     (ex_funct3[1:0]),
    .addr_i     (ex_alu_result[1:0]),
    .rs2_i      (ex_rs2_data),
    .access_i   (ex_ctl[CTL_MEMREAD] | ex_ctl[CTL_MEMWRITE]),
    .write_i    (ex_ctl[CTL_MEMWRITE]),
    .wdata_o    (st_wdata),
    .wstrb_o    (st_wstrb),
    .misalign_o (st_misalign)
  );

  // Branch condition from ALU flags; the decoder picked SUB/SLT/SLTU to suit funct3
  always_comb begin
    cond_met = 1'b0;
    case (ex_funct3)
      F3_BEQ:            cond_met = ex_zero;
      F3_BNE:            cond_met = ~ex_zero;
      F3_BLT,  F3_BLTU:  cond_met = ex_less;
      F3_BGE,  F3_BGEU:  cond_met = ~ex_less;
      default:           cond_met = 1'b0;
    endcase
    taken = ex_valid & (ex_jump | (ex_branch & cond_met));
  end

  // Next-state: a pending redirect squashes whatever EX holds (it is on the wrong path)
  always_comb begin
    stage_d         = stage_q;
    redirect_done_d = redirect_done_q;
    if (flush || redirect_valid) begin
      stage_d         = '0;
      redirect_done_d = 1'b0;
    end else if (stall) begin
      redirect_done_d = 1'b1;
    end else begin
      stage_d.valid              = ex_valid;
      stage_d.pc                 = ex_pc;
      stage_d.alu                = ex_alu_result;
      stage_d.wdata              = st_wdata;
      stage_d.wstrb              = st_wstrb;
      stage_d.rd                 = ex_rd;
      stage_d.ctl                = ex_ctl;
      stage_d.ctl[CTL_MEMWRITE]  = ex_ctl[CTL_MEMWRITE] & ~st_misalign;
      stage_d.funct3             = ex_funct3;
      stage_d.misalign           = st_misalign;
      stage_d.taken              = taken;
      stage_d.target             = ex_target;
      redirect_done_d            = 1'b0;
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q         <= '0;
      redirect_done_q <= 1'b0;
    end else begin
      stage_q         <= stage_d;
      redirect_done_q <= redirect_done_d;
    end
  end

  assign mem_valid      = stage_q.valid;
  assign mem_pc         = stage_q.pc;
  assign mem_alu_result = stage_q.alu;
  assign mem_wdata      = stage_q.wdata;
  assign mem_wstrb      = stage_q.wstrb;
  assign mem_rd         = stage_q.rd;
  assign mem_ctl        = stage_q.ctl;
  assign mem_funct3     = stage_q.funct3;
  assign mem_misalign   = stage_q.misalign;

  assign redirect_valid = stage_q.valid & stage_q.taken & ~redirect_done_q;
  assign redirect_pc    = stage_q.target;

  // Loads are excluded: their data is not known until after MEM
  assign fwd_valid = stage_q.valid & stage_q.ctl[CTL_REGWRITE] & ~stage_q.ctl[CTL_MEMREAD]
                   & (stage_q.rd != '0);
  assign fwd_rd    = stage_q.rd;
  assign fwd_data  = stage_q.alu;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_alu_result, ex_rs2_data, ex_target;
  logic        ex_zero, ex_less;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_ctl;
  logic        ex_branch, ex_jump;

  logic        mem_valid;
  logic [31:0] mem_pc, mem_alu_result, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [4:0]  mem_rd;
  logic [3:0]  mem_ctl;
  logic [2:0]  mem_funct3;
  logic        mem_misalign;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_zero(ex_zero), .ex_less(ex_less), .ex_rs2_data(ex_rs2_data),
    .ex_target(ex_target), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_ctl(ex_ctl),
    .ex_branch(ex_branch), .ex_jump(ex_jump),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rd(mem_rd), .mem_ctl(mem_ctl),
    .mem_funct3(mem_funct3), .mem_misalign(mem_misalign),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic [2:0]  f3;
    logic        mis;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t m;
  logic m_done;

  function automatic exp_t model_capture();
    exp_t e;
    int size;
    int lane;
    bit access, cond;
    e = '0;
    e.valid = ex_valid;
    e.pc = ex_pc;
    e.alu = ex_alu_result;
    e.rd = ex_rd;
    e.f3 = ex_funct3;
    e.tgt = ex_target;
    access = ex_ctl[2] || ex_ctl[1];
    case (ex_funct3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    e.mis = access && (size > 1) && ((ex_alu_result % size) != 0);
    if (size == 1)      e.wdata = {24'h0, ex_rs2_data[7:0]} * 32'h01010101;
    else if (size == 2) e.wdata = {16'h0, ex_rs2_data[15:0]} * 32'h00010001;
    else                e.wdata = ex_rs2_data;
    lane = (size == 0) ? 0 : (ex_alu_result % 4) / size * size;
    e.wstrb = (ex_ctl[1] && !e.mis && size != 0) ? 4'(((1 << size) - 1) << lane) : 4'h0;
    e.ctl = ex_ctl;
    if (e.mis) e.ctl[1] = 1'b0;
    case (ex_funct3)
      3'd0: cond = ex_zero;
      3'd1: cond = !ex_zero;
      3'd4, 3'd6: cond = ex_less;
      3'd5, 3'd7: cond = !ex_less;
      default: cond = 0;
    endcase
    e.taken = ex_valid && (ex_jump || (ex_branch && cond));
    return e;
  endfunction

  function automatic logic exp_redirect();
    return m.valid && m.taken && !m_done;
  endfunction

  function automatic logic exp_fwd();
    return m.valid && m.ctl[3] && !m.ctl[2] && (m.rd != 0);
  endfunction

  // Advance model with the current inputs, then clock the DUT; returns #1 after the edge
  task automatic step();
    if (flush || exp_redirect()) begin
      m = '0;
      m_done = 1'b0;
    end else if (stall) begin
      m_done = 1'b1;
    end else begin
      m = model_capture();
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; ex_valid = 0; ex_pc = 0; ex_alu_result = 0; ex_zero = 0;
    ex_less = 0; ex_rs2_data = 0; ex_target = 0; ex_rd = 0; ex_funct3 = 0; ex_ctl = 0;
    ex_branch = 0; ex_jump = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [3:0] ctl);
    ex_valid = 1; ex_pc = pc; ex_alu_result = alu; ex_rs2_data = rs2;
    ex_rd = rd; ex_funct3 = f3; ex_ctl = ctl; ex_branch = 0; ex_jump = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({mem_valid, mem_pc, mem_alu_result, mem_wstrb, mem_ctl, redirect_valid, fwd_valid} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b pc=%h alu=%h wstrb=%b ctl=%b redir=%b fwd=%b required all 0",
               mem_valid, mem_pc, mem_alu_result, mem_wstrb, mem_ctl, redirect_valid, fwd_valid);
    end
  endtask

  task automatic test_beq_redirect();
    drive(32'h40, 32'h0, 32'h0, 5'd0, 3'b000, 4'b0000);
    ex_branch = 1; ex_zero = 1; ex_target = 32'h100;
    step();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
      errors++;
      $display("FAIL beq_redirect: valid=%b pc=%h required 1 00000100", redirect_valid, redirect_pc);
    end
    drive(32'h44, 32'h77, 32'h0, 5'd3, 3'b000, 4'b1000);
    ex_zero = 0;
    step();
    checks++;
    if (redirect_valid !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL beq_squash: redirect=%b mem_valid=%b required 0 0", redirect_valid, mem_valid);
    end
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_pc !== 32'h44) begin
      errors++;
      $display("FAIL after_squash: mem_valid=%b pc=%h required 1 00000044", mem_valid, mem_pc);
    end
    set_idle();
  endtask

  task automatic test_bgeu_bne_stall();
    int pulses;
    drive(32'h80, 32'h0, 32'h0, 5'd0, 3'b111, 4'b0000);
    ex_branch = 1; ex_less = 1; ex_target = 32'h200;
    step();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL bgeu_not_taken: redirect=%b required 0", redirect_valid);
    end
    drive(32'h84, 32'h5, 32'h0, 5'd0, 3'b001, 4'b0000);
    ex_branch = 1; ex_zero = 0; ex_less = 0; ex_target = 32'h300;
    step();
    pulses = int'(redirect_valid);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(redirect_valid);
    end
    set_idle();
    step();
    pulses += int'(redirect_valid);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bne_stall_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_stores();
    drive(32'h90, 32'h1003, 32'h000000A5, 5'd0, 3'b000, 4'b0010);
    step();
    checks++;
    if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5 || mem_misalign !== 1'b0) begin
      errors++;
      $display("FAIL store_sb: wstrb=%b wdata=%h mis=%b required 1000 a5a5a5a5 0",
               mem_wstrb, mem_wdata, mem_misalign);
    end
    drive(32'h94, 32'h1002, 32'h00001234, 5'd0, 3'b001, 4'b0010);
    step();
    checks++;
    if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'h12341234) begin
      errors++;
      $display("FAIL store_sh: wstrb=%b wdata=%h required 1100 12341234", mem_wstrb, mem_wdata);
    end
    drive(32'h98, 32'h1002, 32'hCAFEBABE, 5'd0, 3'b010, 4'b0010);
    step();
    checks++;
    if (mem_misalign !== 1'b1 || mem_wstrb !== 4'b0000 || mem_ctl[1] !== 1'b0) begin
      errors++;
      $display("FAIL store_sw_misalign: mis=%b wstrb=%b memwrite=%b required 1 0000 0",
               mem_misalign, mem_wstrb, mem_ctl[1]);
    end
    drive(32'h9C, 32'h1001, 32'h0, 5'd4, 3'b101, 4'b1101);
    step();
    checks++;
    if (mem_misalign !== 1'b1 || mem_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL load_lhu_misalign: mis=%b wstrb=%b required 1 0000", mem_misalign, mem_wstrb);
    end
    set_idle();
  endtask

  task automatic test_forward();
    drive(32'hA0, 32'h0000DEAD, 32'h0, 5'd5, 3'b000, 4'b1000);
    step();
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL fwd_add: valid=%b rd=%0d data=%h required 1 5 0000dead", fwd_valid, fwd_rd, fwd_data);
    end
    drive(32'hA4, 32'h00001111, 32'h0, 5'd0, 3'b000, 4'b1000);
    step();
    checks++;
    if (fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_rd0: valid=%b required 0", fwd_valid);
    end
    drive(32'hA8, 32'h00002000, 32'h0, 5'd5, 3'b010, 4'b1101);
    step();
    checks++;
    if (fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_load: valid=%b required 0", fwd_valid);
    end
    set_idle();
  endtask

  task automatic test_flush_stall();
    drive(32'hB0, 32'h55, 32'h0, 5'd7, 3'b000, 4'b1000);
    step();
    drive(32'hB4, 32'h66, 32'h0, 5'd8, 3'b000, 4'b1000);
    flush = 1; stall = 1;
    step();
    checks++;
    if (mem_valid !== 1'b0 || fwd_valid !== 1'b0 || mem_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_stall: valid=%b fwd=%b pc=%h required 0 0 00000000", mem_valid, fwd_valid, mem_pc);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 8);
      ex_valid = ($urandom_range(0, 99) < 85);
      ex_pc = $urandom & 32'hFFFF_FFFC;
      ex_alu_result = $urandom;
      ex_zero = 1'($urandom);
      ex_less = 1'($urandom);
      ex_rs2_data = $urandom;
      ex_target = $urandom & 32'hFFFF_FFFC;
      ex_rd = 5'($urandom);
      ex_funct3 = 3'($urandom);
      ex_ctl = 4'($urandom);
      ex_branch = ($urandom_range(0, 99) < 30);
      ex_jump = ($urandom_range(0, 99) < 10);
      step();
      checks++;
      if ({mem_valid, mem_pc, mem_alu_result, mem_wdata, mem_wstrb, mem_rd, mem_ctl, mem_funct3,
           mem_misalign, redirect_pc} !==
          {m.valid, m.pc, m.alu, m.wdata, m.wstrb, m.rd, m.ctl, m.f3, m.mis, m.tgt}) begin
        errors++;
        $display("FAIL rand_stage[%0d]: v=%b pc=%h alu=%h wd=%h st=%b rd=%0d ctl=%b f3=%b mis=%b tgt=%h required v=%b pc=%h alu=%h wd=%h st=%b rd=%0d ctl=%b f3=%b mis=%b tgt=%h",
                 n, mem_valid, mem_pc, mem_alu_result, mem_wdata, mem_wstrb, mem_rd, mem_ctl, mem_funct3,
                 mem_misalign, redirect_pc, m.valid, m.pc, m.alu, m.wdata, m.wstrb, m.rd, m.ctl, m.f3,
                 m.mis, m.tgt);
      end
      checks++;
      if (redirect_valid !== exp_redirect() || fwd_valid !== exp_fwd() ||
          fwd_rd !== m.rd || fwd_data !== m.alu) begin
        errors++;
        $display("FAIL rand_redir_fwd[%0d]: redir=%b fwd=%b rd=%0d data=%h required %b %b %0d %h",
                 n, redirect_valid, fwd_valid, fwd_rd, fwd_data, exp_redirect(), exp_fwd(), m.rd, m.alu);
      end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    drive(32'hC0, 32'h123, 32'h0, 5'd9, 3'b000, 4'b1000);
    ex_jump = 1; ex_target = 32'h400;
    step();
    checks++;
    if (mem_valid !== 1'b1 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: valid=%b redirect=%b required 1 1", mem_valid, redirect_valid);
    end
    set_idle();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({mem_valid, redirect_valid, redirect_pc, fwd_valid, fwd_data, mem_pc, mem_rd} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b redirect=%b rpc=%h fwd=%b fdata=%h pc=%h rd=%0d required all 0",
               mem_valid, redirect_valid, redirect_pc, fwd_valid, fwd_data, mem_pc, mem_rd);
    end
    m = '0;
    m_done = 0;
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    m = '0;
    m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    test_beq_redirect();
    test_bgeu_bne_stall();
    test_stores();
    test_forward();
    test_flush_stall();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
